// File: rtl/logic_unit_arbiter_if.sv
// Request/operand/result bundle between the two requesters and logic_unit_arbiter.
// The requester side uses the master modport, the arbiter uses the slave modport.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             key0;
  logic             key1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] r;
  logic             r_valid;
  logic             r_id;
  logic             busy;
  logic [7:0]       op_count;

  modport master (
    output req0, req1, x0, y0, x1, y1, key0, key1,
    input  ack0, ack1, r, r_valid, r_id, busy, op_count
  );

  modport slave (
    input  req0, req1, x0, y0, x1, y1, key0, key1,
    output ack0, ack1, r, r_valid, r_id, busy, op_count
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of an OR/NOR logic unit: IDLE -> EXEC -> DONE, one op per 3 cycles.
// Define LOGIC_UNIT_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  logic_unit_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             key_q, key_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             r_id_q, r_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             r_valid_q, r_valid_d;
  logic             busy_q, busy_d;
  logic             capture_c;
  logic             complete_c;
  logic             win_c;

`ifdef LOGIC_UNIT_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the requester that was not granted last wins
  always_comb begin
    win_c  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    last_d = capture_c ? win_c : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  // req0 always wins when both are pending
  always_comb begin
    win_c = ~bus.req0;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    capture_c  = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d   = EXEC;
          capture_c = 1'b1;
        end
      end
      EXEC: begin
        state_d    = DONE;
        complete_c = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    x_d   = x_q;
    y_d   = y_q;
    key_d = key_q;
    id_d  = id_q;
    if (capture_c) begin
      x_d   = win_c ? bus.x1   : bus.x0;
      y_d   = win_c ? bus.y1   : bus.y0;
      key_d = win_c ? bus.key1 : bus.key0;
      id_d  = win_c;
    end

    r_d    = r_q;
    r_id_d = r_id_q;
    cnt_d  = cnt_q;
    if (complete_c) begin
      r_d    = key_q ? ~(x_q | y_q) : (x_q | y_q);
      r_id_d = id_q;
      cnt_d  = cnt_q + CNT_W'(1);
    end

    ack0_d    = capture_c && !win_c;
    ack1_d    = capture_c && win_c;
    r_valid_d = complete_c;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      key_q     <= 1'b0;
      id_q      <= 1'b0;
      r_q       <= '0;
      r_id_q    <= 1'b0;
      cnt_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      r_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      key_q     <= key_d;
      id_q      <= id_d;
      r_q       <= r_d;
      r_id_q    <= r_id_d;
      cnt_q     <= cnt_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      r_valid_q <= r_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.r        = r_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_id     = r_id_q;
  assign bus.busy     = busy_q;
  assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table, hand sequences and a
// randomized run against a transaction-scheduling reference model.
module tb_logic_unit_arbiter;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;

  logic_unit_arbiter_if #(.WIDTH(W)) bus ();

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: an operation accepted in cycle s acks in s+1, completes in s+2,
  // and the arbiter may accept again from s+3.
  int         cyc;
  int         free_at;
  int         ack_cyc;
  int         done_cyc;
  bit         win;
  bit         last_g;
  logic [W-1:0] res_pend;
  logic [W-1:0] exp_r;
  bit         exp_id;
  int         exp_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_init();
    cyc      = 0;
    free_at  = 0;
    ack_cyc  = -100;
    done_cyc = -100;
    win      = 1'b0;
    last_g   = 1'b1;
    res_pend = '0;
    exp_r    = '0;
    exp_id   = 1'b0;
    exp_cnt  = 0;
  endtask

  task automatic check_outputs();
    check("ack0",     32'(bus.ack0),     32'(cyc == ack_cyc && win == 1'b0));
    check("ack1",     32'(bus.ack1),     32'(cyc == ack_cyc && win == 1'b1));
    check("r_valid",  32'(bus.r_valid),  32'(cyc == done_cyc));
    check("busy",     32'(bus.busy),     32'(cyc == ack_cyc || cyc == done_cyc));
    check("r",        32'(bus.r),        32'(exp_r));
    check("r_id",     32'(bus.r_id),     32'(exp_id));
    check("op_count", 32'(bus.op_count), 32'(exp_cnt));
  endtask

  // Let the model see the current inputs, advance one clock, then compare
  task automatic tick();
    logic [W-1:0] xv, yv;
    bit kv;
    if (cyc >= free_at && (bus.req0 || bus.req1)) begin
`ifdef LOGIC_UNIT_ARB_RR_EN
      if (bus.req0 && bus.req1) win = ~last_g;
      else                      win = bus.req1;
      last_g = win;
`else
      win = bus.req0 ? 1'b0 : 1'b1;
`endif
      xv = win ? bus.x1 : bus.x0;
      yv = win ? bus.y1 : bus.y0;
      kv = win ? bus.key1 : bus.key0;
      res_pend = kv ? ~(xv | yv) : (xv | yv);
      ack_cyc  = cyc + 1;
      done_cyc = cyc + 2;
      free_at  = cyc + 3;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == done_cyc) begin
      exp_r   = res_pend;
      exp_id  = win;
      exp_cnt = (exp_cnt + 1) % 256;
    end
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
    check_outputs();
  endtask

  typedef struct {
    bit           sel;
    logic [W-1:0] x;
    logic [W-1:0] y;
    bit           key;
    logic [W-1:0] exp_r;
  } vec_t;

  vec_t vecs[7];
  int   order[4];

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.key0 = 1'b0; bus.key1 = 1'b0;
    reset = 1'b1;
    model_init();

    vecs[0] = '{1'b0, 4'b0011, 4'b0101, 1'b0, 4'b0111};
    vecs[1] = '{1'b1, 4'b0011, 4'b0101, 1'b1, 4'b1000};
    vecs[2] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1111};
    vecs[3] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000};
    vecs[4] = '{1'b1, 4'b1000, 4'b0001, 1'b0, 4'b1001};
    vecs[5] = '{1'b0, 4'b1010, 4'b0101, 1'b0, 4'b1111};
    vecs[6] = '{1'b0, 4'b1100, 4'b0000, 1'b1, 4'b0011};

    repeat (2) @(posedge clk);
    do_reset();

    // Single-request vectors; operands are scrambled after capture
    for (int i = 0; i < 7; i++) begin
      bus.x0 = W'($urandom); bus.y0 = W'($urandom); bus.key0 = 1'($urandom);
      bus.x1 = W'($urandom); bus.y1 = W'($urandom); bus.key1 = 1'($urandom);
      if (vecs[i].sel) begin
        bus.req1 = 1'b1; bus.x1 = vecs[i].x; bus.y1 = vecs[i].y; bus.key1 = vecs[i].key;
      end else begin
        bus.req0 = 1'b1; bus.x0 = vecs[i].x; bus.y0 = vecs[i].y; bus.key0 = vecs[i].key;
      end
      tick();
      check("vec_ack", 32'(vecs[i].sel ? bus.ack1 : bus.ack0), 32'd1);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.x0 = ~bus.x0; bus.y0 = ~bus.y0; bus.key0 = ~bus.key0;
      bus.x1 = ~bus.x1; bus.y1 = ~bus.y1; bus.key1 = ~bus.key1;
      tick();
      check("vec_r",       32'(bus.r),        32'(vecs[i].exp_r));
      check("vec_r_id",    32'(bus.r_id),     32'(vecs[i].sel));
      check("vec_r_valid", 32'(bus.r_valid),  32'd1);
      check("vec_count",   32'(bus.op_count), 32'(i + 1));
      tick();
    end

    // Reset during EXEC abandons the operation
    bus.req0 = 1'b1; bus.x0 = 4'b0110; bus.y0 = 4'b0001; bus.key0 = 1'b0;
    tick();
    check("rst_exec_ack", 32'(bus.ack0), 32'd1);
    bus.req0 = 1'b0;
    do_reset();
    check("rst_r",     32'(bus.r),        32'd0);
    check("rst_count", 32'(bus.op_count), 32'd0);
    repeat (3) begin
      tick();
      check("rst_no_valid", 32'(bus.r_valid), 32'd0);
    end

    // Both requesters held high continuously
`ifdef LOGIC_UNIT_ARB_RR_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0};
`endif
    do_reset();
    bus.req0 = 1'b1; bus.x0 = 4'b0001; bus.y0 = 4'b0010; bus.key0 = 1'b0;
    bus.req1 = 1'b1; bus.x1 = 4'b0100; bus.y1 = 4'b1000; bus.key1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      check("rr_valid", 32'(bus.r_valid), 32'd1);
      check("rr_order", 32'(bus.r_id),    32'(order[k]));
      tick();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) tick();

    // 256 back-to-back req0 operations wrap op_count
    do_reset();
    bus.req0 = 1'b1; bus.x0 = 4'b1001; bus.y0 = 4'b0100; bus.key0 = 1'b1;
    while (cyc < 767) begin
      tick();
      check("b2b_busy", 32'(bus.busy), 32'((cyc % 3) != 0));
      if (cyc == 764) check("b2b_count255", 32'(bus.op_count), 32'd255);
      if (cyc == 766) bus.req0 = 1'b0;
    end
    check("b2b_wrap", 32'(bus.op_count), 32'd0);
    repeat (2) tick();

    // Randomized traffic; a requester drops req once acked and may re-raise later
    do_reset();
    for (int n = 0; n < 900; n++) begin
      if (cyc == ack_cyc) begin
        if (win) begin
          bus.req1 = 1'b0; bus.x1 = W'($urandom); bus.y1 = W'($urandom); bus.key1 = 1'($urandom);
        end else begin
          bus.req0 = 1'b0; bus.x0 = W'($urandom); bus.y0 = W'($urandom); bus.key0 = 1'($urandom);
        end
      end
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1; bus.x0 = W'($urandom); bus.y0 = W'($urandom); bus.key0 = 1'($urandom);
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1; bus.x1 = W'($urandom); bus.y1 = W'($urandom); bus.key1 = 1'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
